// File: rtl/spi_axi_txn_scheduler.sv
// Two-requester scheduler for single-beat AXI4-Lite transactions on the shared
// M00_AXI master engine: round-robin grant, init pulse, timed wait, retry, tagged response.
module spi_axi_txn_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024,
  parameter int MAX_RETRY          = 2
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0]                    req_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] req_addr0,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] req_addr1,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] req_wdata0,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] req_wdata1,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_id,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_err,
  output logic                          init_w_axi_txn,
  output logic                          init_r_axi_txn,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] user_awaddr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] user_araddr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] user_wdata,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] user_rdata,
  input  logic                          done_w_axi_txn,
  input  logic                          done_r_axi_txn,
  input  logic                          error_w_axi_txn,
  input  logic                          error_r_axi_txn
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                        r_state;
  logic                          r_last_grant;
  logic [RW-1:0]                 r_retry_cnt;
  logic [CW-1:0]                 r_tmo_cnt;
  logic                          r_wr;
  logic                          r_rsp_id;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]                    r_rsp_err;
  logic                          r_init_w;
  logic                          r_init_r;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;

  logic w_grant;
  logic w_accept;
  logic w_done;
  logic w_err;

  // The requester not served last wins contention; a lone requester always wins.
  // NOTE: w_grant gets a default before the ifs so no latch is inferred.
  always_comb begin
    w_grant = 1'b0;
    if (&req_valid)        w_grant = ~r_last_grant;
    else if (req_valid[1]) w_grant = 1'b1;
  end

  assign w_accept  = (r_state == S_IDLE) && !M_AXI_ARESET && req_valid[w_grant];
  assign req_ready = {w_grant, ~w_grant} & {2{w_accept}};

  // Only the pair matching the captured direction is observed.
  assign w_done = r_wr ? done_w_axi_txn  : done_r_axi_txn;
  assign w_err  = r_wr ? error_w_axi_txn : error_r_axi_txn;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_retry_cnt  <= '0;
      r_tmo_cnt    <= '0;
      r_wr         <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 2'b00;
      r_init_w     <= 1'b0;
      r_init_r     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_init_w <= 1'b0;
      r_init_r <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr        <= req_wr[w_grant];
            r_addr      <= w_grant ? req_addr1  : req_addr0;
            r_wdata     <= w_grant ? req_wdata1 : req_wdata0;
            r_rsp_id    <= w_grant;
            r_retry_cnt <= '0;
            r_init_w    <= req_wr[w_grant];
            r_init_r    <= ~req_wr[w_grant];
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tmo_cnt <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (w_err) begin
            if (r_retry_cnt < RW'(MAX_RETRY)) begin
              r_retry_cnt <= r_retry_cnt + 1'b1;
              r_init_w    <= r_wr;
              r_init_r    <= ~r_wr;
              r_state     <= S_ISSUE;
            end else begin
              r_rsp_err   <= 2'b10;
              r_rsp_rdata <= '0;
              r_state     <= S_RESP;
            end
          end else if (w_done) begin
            r_rsp_err   <= 2'b00;
            r_rsp_rdata <= r_wr ? '0 : user_rdata;
            r_state     <= S_RESP;
          end else if (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_err   <= 2'b11;
            r_rsp_rdata <= '0;
            r_state     <= S_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_last_grant <= r_rsp_id;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid      = (r_state == S_RESP);
  assign rsp_id         = r_rsp_id;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_err        = r_rsp_err;
  assign init_w_axi_txn = r_init_w;
  assign init_r_axi_txn = r_init_r;
  assign user_awaddr    = r_addr;
  assign user_araddr    = r_addr;
  assign user_wdata     = r_wdata;

endmodule

// File: tb/tb_spi_axi_txn_scheduler.sv
// Directed bench for spi_axi_txn_scheduler: vector table driving a scripted
// engine model, plus reset-in-flight and contention sequences.
module tb_spi_axi_txn_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_wr = 2'b00;
  logic [31:0] req_addr0 = '0, req_addr1 = '0;
  logic [31:0] req_wdata0 = '0, req_wdata1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        init_w, init_r;
  logic [31:0] user_awaddr, user_araddr, user_wdata;
  logic [31:0] user_rdata = 32'hBAD0_BAD0;
  logic        done_w = 1'b0, done_r = 1'b0, error_w = 1'b0, error_r = 1'b0;

  always #5 clk = ~clk;

  spi_axi_txn_scheduler #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8), .MAX_RETRY(2)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_w_axi_txn(init_w), .init_r_axi_txn(init_r),
    .user_awaddr(user_awaddr), .user_araddr(user_araddr), .user_wdata(user_wdata),
    .user_rdata(user_rdata),
    .done_w_axi_txn(done_w), .done_r_axi_txn(done_r),
    .error_w_axi_txn(error_w), .error_r_axi_txn(error_r)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Engine model: answers each init pulse after eng_delay cycles. Attempts
  // 1..eng_nerr get an error (plus done when eng_both); later ones get done.
  int          n_init = 0;
  int          eng_nerr = 0;
  int          eng_delay = 1;
  bit          eng_both = 0;
  bit          eng_silent = 0;
  logic [31:0] eng_rdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      while (init_w || init_r) begin
        automatic bit dir_w = init_w;
        n_init++;
        if (eng_silent) begin
          @(negedge clk);
        end else begin
          repeat (eng_delay) @(negedge clk);
          if (n_init <= eng_nerr) begin
            if (dir_w) begin error_w = 1'b1; done_w = eng_both; end
            else       begin error_r = 1'b1; done_r = eng_both; end
          end else begin
            // The opposite-direction error must be ignored by the scheduler.
            if (dir_w) begin done_w = 1'b1; error_r = 1'b1; end
            else       begin done_r = 1'b1; error_w = 1'b1; user_rdata = eng_rdata; end
          end
          @(negedge clk);
          {done_w, done_r, error_w, error_r} = 4'b0000;
          user_rdata = 32'hBAD0_BAD0;
        end
      end
    end
  end

  typedef struct {
    bit          id;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nerr;
    bit          both;
    bit          silent;
    int          delay;
    logic [31:0] rdata;
    int          hold;
    int          exp_lat;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
    int          exp_inits;
  } vec_t;

  task automatic do_txn(input int idx, input vec_t v);
    int lat;
    string p;
    p = $sformatf("v%0d", idx);
    n_init     = 0;
    eng_nerr   = v.nerr;
    eng_both   = v.both;
    eng_silent = v.silent;
    eng_delay  = v.delay;
    eng_rdata  = v.rdata;
    @(negedge clk);
    req_wr[v.id] = v.wr;
    if (v.id) begin req_addr1 = v.addr; req_wdata1 = v.wdata; end
    else      begin req_addr0 = v.addr; req_wdata0 = v.wdata; end
    req_valid[v.id] = 1'b1;
    #1;
    check({p, "_req_ready"}, 32'(req_ready), 32'(2'b01 << v.id));
    @(negedge clk);
    req_valid = 2'b00;
    check({p, "_init_w"}, 32'(init_w), 32'(v.wr));
    check({p, "_init_r"}, 32'(init_r), 32'(!v.wr));
    check({p, "_awaddr"}, user_awaddr, v.addr);
    check({p, "_araddr"}, user_araddr, v.addr);
    check({p, "_wdata"}, user_wdata, v.wdata);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({p, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({p, "_latency"}, 32'(lat), 32'(v.exp_lat));
    repeat (v.hold) @(negedge clk);
    check({p, "_rsp_held"}, 32'(rsp_valid), 32'd1);
    check({p, "_rsp_id"}, 32'(rsp_id), 32'(v.id));
    check({p, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    check({p, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({p, "_inits"}, 32'(n_init), 32'(v.exp_inits));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check({p, "_rsp_dropped"}, 32'(rsp_valid), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int  cnt;
    bit  seen;
    // id wr addr wdata nerr both silent delay rdata hold lat err rdata inits
    vecs[0] = '{0, 1, 32'h40, 32'hA5A5_0001, 0, 0, 0, 3, 32'h0,         2, 5,  2'b00, 32'h0,         1};
    vecs[1] = '{1, 0, 32'h10, 32'h0,         0, 0, 0, 2, 32'hDEAD_BEEF, 0, 4,  2'b00, 32'hDEAD_BEEF, 1};
    vecs[2] = '{0, 1, 32'h80, 32'h1111_2222, 2, 0, 0, 1, 32'h0,         0, 7,  2'b00, 32'h0,         3};
    vecs[3] = '{1, 1, 32'h84, 32'h3333_4444, 3, 0, 0, 1, 32'h0,         1, 7,  2'b10, 32'h0,         3};
    vecs[4] = '{0, 0, 32'h20, 32'h0,         0, 0, 1, 1, 32'h0,         0, 10, 2'b11, 32'h0,         1};
    vecs[5] = '{1, 0, 32'h24, 32'h0,         1, 1, 0, 2, 32'h1234_5678, 0, 7,  2'b00, 32'h1234_5678, 2};
    vecs[6] = '{0, 0, 32'h28, 32'h0,         3, 0, 0, 2, 32'hCAFE_0000, 0, 10, 2'b10, 32'h0,         3};

    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_init", 32'({init_w, init_r}), 32'd0);
    check("rst_awaddr", user_awaddr, 32'd0);
    check("rst_wdata", user_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_txn(i, vecs[i]);

    // Reset while waiting on a silent engine: no response must follow.
    n_init = 0; eng_silent = 1;
    @(negedge clk);
    req_wr[1] = 1'b0; req_addr1 = 32'h0000_0F00; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstw_araddr", user_araddr, 32'd0);
    check("rstw_init", 32'({init_w, init_r}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin @(negedge clk); if (rsp_valid) seen = 1; end
    check("rstw_no_rsp", 32'(seen), 32'd0);

    // Reset while a response is pending.
    n_init = 0; eng_silent = 0; eng_nerr = 0; eng_delay = 1; eng_rdata = 32'h5555_AAAA;
    @(negedge clk);
    req_wr[1] = 1'b0; req_addr1 = 32'h0000_0F04; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid = 2'b00;
    cnt = 0;
    while (!rsp_valid && cnt < 50) begin @(negedge clk); cnt++; end
    check("rstr_reached_resp", 32'(rsp_valid), 32'd1);
    check("rstr_rdata_before", rsp_rdata, 32'h5555_AAAA);
    #3 rst = 1'b1;
    #1;
    check("rstr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstr_rsp_id", 32'(rsp_id), 32'd0);
    check("rstr_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen = 1; end
    check("rstr_no_rsp", 32'(seen), 32'd0);

    // Continuous contention after reset: grants alternate starting with 0.
    rsp_ready = 1'b1; eng_rdata = 32'h0BAD_F00D;
    req_wr = 2'b00; req_addr0 = 32'h100; req_addr1 = 32'h200;
    req_valid = 2'b11;
    #1;
    for (int t = 0; t < 4; t++) begin
      automatic int exp_g = t % 2;
      cnt = 0;
      while (req_ready == 2'b00 && cnt < 50) begin @(negedge clk); #1; cnt++; end
      check($sformatf("cont%0d_grant", t), 32'(req_ready), 32'(2'b01 << exp_g));
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!rsp_valid && cnt < 50);
      check($sformatf("cont%0d_rsp_id", t), 32'(rsp_id), 32'(exp_g));
      check($sformatf("cont%0d_rsp_err", t), 32'(rsp_err), 32'd0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
